key_board_encoder: RTL and testbench
====================================

KEY_BOARD_ENCODER -- requirements
Module: key_board_encoder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2500, giving the system clocks per PS/2 clock half-period.
REQ-002 SHALL have parameter GAP_CYCLES, default 5000, giving the idle clocks between consecutive frames.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enter  input  1  1-cycle request to transmit the Enter key (set-2 make code 0x5A).
REQ-007 space  input  1  1-cycle request to transmit the Space key (set-2 make code 0x29).
REQ-008 ps2_clk  output  1  device-driven PS/2 clock; idles 1.
REQ-009 ps2_data  output  1  device-driven PS/2 data; idles 1.
REQ-010 busy  output  1  high while a key sequence is in progress.
REQ-011 done  output  1  1-cycle pulse when a key sequence completes.

Function
REQ-012 SHALL use FSM states IDLE, BIT_HI, BIT_LO, GAP.
REQ-013 SHALL keep one pending flag per key; a request sets its flag; a request whose flag is already set is ignored.
REQ-014 IDLE with any flag set: SHALL select Enter if its flag is set, else Space; SHALL clear that flag, assert busy, load the first byte and go to BIT_HI on the next cycle.
REQ-015 Simultaneous enter and space SHALL send Enter first, then Space, with no lost request.
REQ-016 Each frame SHALL be 11 bits: start 0, data LSB first, odd parity, stop 1.
REQ-017 BIT_HI: ps2_data SHALL present the current bit and ps2_clk SHALL be 1 for CLK_DIV cycles; then go to BIT_LO.
REQ-018 BIT_LO: ps2_clk SHALL be 0 for CLK_DIV cycles with ps2_data held; then go to BIT_HI for the next bit, or to GAP after the stop bit.
REQ-019 ps2_data SHALL change only while ps2_clk is 1; one frame SHALL last exactly 22*CLK_DIV cycles.
REQ-020 GAP: ps2_clk and ps2_data SHALL be 1 for GAP_CYCLES cycles.
REQ-021 After GAP, SHALL start the next byte of the sequence, or, if none remain, go to IDLE.
REQ-022 On entry to IDLE, SHALL drop busy and pulse done for exactly one cycle.
REQ-023 A new sequence MAY start the cycle after done.
REQ-024 Parity SHALL be computed over the 8 data bits so that the 9 bits contain an odd number of ones.

Reset
REQ-025 reset low SHALL immediately force ps2_clk=1, ps2_data=1, busy=0 and done=0.
REQ-026 reset low SHALL also clear both pending flags and all counters and set the state to IDLE.
REQ-027 Reset mid-frame SHALL abort the frame with no completion of partial bits; after reset release, nothing is sent until a new request arrives.

Configuration
REQ-028 With macro KEY_BREAK_EN defined, each sequence SHALL be 3 frames: make code, then 0xF0, then make code.
REQ-029 With KEY_BREAK_EN undefined, each sequence SHALL be the make-code frame only; the 0xF0 logic SHALL be absent.

Verification (CLK_DIV=4, GAP_CYCLES=8)
REQ-030 Without KEY_BREAK_EN, enter pulse -> bits 0,0,1,0,1,1,0,1,0,1,1 (0x5A, parity 1) sampled on ps2_clk falling edges.
REQ-031 Continuing REQ-030 -> frame occupies 88 cycles, then 8 gap cycles, then a done pulse, then busy=0.
REQ-032 With KEY_BREAK_EN, space pulse -> frames 0x29 (parity 0), 0xF0 (parity 1), 0x29.
REQ-033 Continuing REQ-032 -> done exactly 3*(88+8) cycles after busy rises.
REQ-034 enter and space in the same cycle -> complete Enter sequence, then Space sequence with no idle gap beyond GAP, and two done pulses.
REQ-035 Second enter pulse during an Enter sequence -> exactly one further Enter sequence; a third pulse while the flag is pending -> ignored.
REQ-036 reset asserted during bit 5 of a frame -> ps2_clk=1 and ps2_data=1 in the same cycle, busy=0, and no output activity after release without a new request.

Source files
------------

// File: rtl/key_board_encoder.sv
// key_board_encoder
//   Emulates a PS/2 keyboard sending set-2 scan codes for two keys.
//   A one-cycle request on enter or space latches a per-key pending flag.
//   When idle, the encoder picks a pending key (Enter wins over Space) and
//   serialises its scan-code sequence as 11-bit PS/2 frames:
//     start 0, 8 data bits LSB first, odd parity, stop 1.
//   Each bit is a high half-period followed by a low half-period of
//   CLK_DIV system clocks. After every frame the lines idle for
//   GAP_CYCLES clocks.
//
//   Optional feature (macro KEY_BREAK_EN):
//     defined   -> each key sends make, 0xF0, make (three frames)
//     undefined -> each key sends the make code only (one frame)
//
// Parameters
//   CLK_DIV     system clocks per PS/2 clock half-period (>= 1)
//   GAP_CYCLES  idle clocks after each frame (>= 1)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   enter     in   1-cycle request: Enter key (make 0x5A)
//   space     in   1-cycle request: Space key (make 0x29)
//   ps2_clk   out  PS/2 clock, idles 1
//   ps2_data  out  PS/2 data, idles 1
//   busy      out  high while a key sequence is in progress
//   done      out  1-cycle pulse when a key sequence completes

module key_board_encoder #(
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_CYCLES = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic enter,
  input  logic space,
  output logic ps2_clk,
  output logic ps2_data,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam logic [7:0] ENTER_CODE = 8'h5A;
  localparam logic [7:0] SPACE_CODE = 8'h29;
`ifdef KEY_BREAK_EN
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [1:0] LAST_BYTE  = 2'd2;
`endif

  // One counter serves both the half-period and the inter-frame gap.
  localparam int unsigned CNT_TOP  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CW       = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'd10;

  // Frame image, bit 0 is the next bit on the wire: {stop, parity, data, start}
  function automatic logic [10:0] build_frame(input logic [7:0] code);
    return {1'b1, ~^code, code, 1'b0};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bitn_q, bitn_d;
  logic [10:0]     frame_q, frame_d;
  logic            enter_pend_q, enter_pend_d;
  logic            space_pend_q, space_pend_d;
  logic            done_q, done_d;
  logic            clr_enter, clr_space;
  logic [7:0]      code_sel;
`ifdef KEY_BREAK_EN
  logic [7:0]      key_q, key_d;
  logic [1:0]      byte_q, byte_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitn_q       <= '0;
      frame_q      <= '1;
      enter_pend_q <= 1'b0;
      space_pend_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef KEY_BREAK_EN
      key_q        <= '0;
      byte_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitn_q       <= bitn_d;
      frame_q      <= frame_d;
      enter_pend_q <= enter_pend_d;
      space_pend_q <= space_pend_d;
      done_q       <= done_d;
`ifdef KEY_BREAK_EN
      key_q        <= key_d;
      byte_q       <= byte_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitn_d    = bitn_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    clr_enter = 1'b0;
    clr_space = 1'b0;
    code_sel  = '0;
`ifdef KEY_BREAK_EN
    key_d     = key_q;
    byte_d    = byte_q;
`endif

    case (state_q)
      IDLE: begin
        if (enter_pend_q || space_pend_q) begin
          code_sel  = enter_pend_q ? ENTER_CODE : SPACE_CODE;
          clr_enter = enter_pend_q;
          clr_space = ~enter_pend_q;
          frame_d   = build_frame(code_sel);
          cnt_d     = '0;
          bitn_d    = '0;
          state_d   = BIT_HI;
`ifdef KEY_BREAK_EN
          key_d     = code_sel;
          byte_d    = '0;
`endif
        end
      end

      BIT_HI: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = BIT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      BIT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bitn_q == BIT_LAST) begin
            state_d = GAP;
          end else begin
            // Shift only here so data never moves while ps2_clk is low.
            bitn_d  = bitn_q + 4'd1;
            frame_d = {1'b1, frame_q[10:1]};
            state_d = BIT_HI;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
`ifdef KEY_BREAK_EN
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 2'd1;
            frame_d = build_frame((byte_q == 2'd0) ? BREAK_CODE : key_q);
            bitn_d  = '0;
            state_d = BIT_HI;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A request is only taken when its flag was clear at that edge; a flag
    // being consumed in the same cycle counts as still set.
    enter_pend_d = (enter_pend_q & ~clr_enter) | (enter & ~enter_pend_q);
    space_pend_d = (space_pend_q & ~clr_space) | (space & ~space_pend_q);
  end

  // Outputs decode straight from registered state so reset forces them at once.
  assign busy     = (state_q != IDLE);
  assign ps2_clk  = (state_q != BIT_LO);
  assign ps2_data = ((state_q == BIT_HI) || (state_q == BIT_LO)) ? frame_q[0] : 1'b1;
  assign done     = done_q;

endmodule

// File: tb/tb_key_board_encoder.sv
// Bench for key_board_encoder with CLK_DIV=4, GAP_CYCLES=8.
// A timeline model derives every output from the cycle offset since the
// sequence started; a compare process checks it each falling clock edge.
// Directed tests add literal checks of frames, durations and reset.

module tb_key_board_encoder;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int FL = 22 * CLK_DIV + GAP_CYCLES;   // 96 cycles per frame slot
`ifdef KEY_BREAK_EN
  localparam int SEQ_FRAMES = 3;
  localparam int SEQ_CYC    = 288;
`else
  localparam int SEQ_FRAMES = 1;
  localparam int SEQ_CYC    = 96;
`endif

  // Wire order, index 0 first: start, data LSB..MSB, parity, stop
  localparam logic [10:0] ENTER_FRAME = 11'b110_1011_0100;
  localparam logic [10:0] SPACE_FRAME = 11'b100_0101_0010;
  localparam logic [10:0] BREAK_FRAME = 11'b111_1110_0000;

  logic clk, rst_n, enter, space;
  logic ps2_clk, ps2_data, busy, done;

  key_board_encoder #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .reset(rst_n), .enter(enter), .space(space),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- model ----------------
  bit         m_active = 0;
  int         m_off = 0;
  bit         m_done = 0;
  bit         m_enp = 0, m_spp = 0;
  logic [7:0] m_code = 8'h00;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 0; m_off = 0; m_done = 0; m_enp = 0; m_spp = 0;
    end else begin
      bit ce, cs, oe, os;
      ce = 0; cs = 0;
      m_done = 0;
      if (!m_active) begin
        if (m_enp || m_spp) begin
          m_active = 1;
          m_off = 0;
          m_code = m_enp ? 8'h5A : 8'h29;
          if (m_enp) ce = 1; else cs = 1;
        end
      end else begin
        m_off++;
        if (m_off == SEQ_FRAMES * FL) begin
          m_active = 0;
          m_done = 1;
        end
      end
      oe = m_enp; os = m_spp;
      m_enp = (oe & ~ce) | (enter & ~oe);
      m_spp = (os & ~cs) | (space & ~os);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic e_clk, e_dat, e_busy, e_done;
      logic [10:0] fr;
      logic [7:0] byt;
      int f, w, b;
      if (!m_active) begin
        e_clk = 1; e_dat = 1; e_busy = 0; e_done = m_done;
      end else begin
        f = m_off / FL;
        w = m_off % FL;
        byt = (SEQ_FRAMES == 3 && f == 1) ? 8'hF0 : m_code;
        fr = frame_of(byt);
        e_busy = 1; e_done = 0;
        if (w < 22 * CLK_DIV) begin
          b = w / (2 * CLK_DIV);
          e_clk = (w % (2 * CLK_DIV)) < CLK_DIV;
          e_dat = fr[b];
        end else begin
          e_clk = 1; e_dat = 1;
        end
      end
      check("model_ps2_clk", 32'(ps2_clk), 32'(e_clk));
      check("model_ps2_data", 32'(ps2_data), 32'(e_dat));
      check("model_busy", 32'(busy), 32'(e_busy));
      check("model_done", 32'(done), 32'(e_done));
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int dur_q[$];
  int gap_q[$];
  int done_cnt = 0;
  int start_cyc = 0, last_done = 0;
  bit have_done = 0;
  logic busy_prev = 0;

  initial forever begin
    @(negedge clk);
    if (busy === 1'b1 && busy_prev !== 1'b1) begin
      start_cyc = cyc;
      if (have_done) gap_q.push_back(cyc - last_done);
    end
    if (done === 1'b1) begin
      dur_q.push_back(cyc - start_cyc);
      done_cnt++;
      last_done = cyc;
      have_done = 1;
    end
    busy_prev = busy;
  end

  logic [10:0] cap_bits;
  int cap_n = 0;
  logic [10:0] cap_q[$];

  initial forever begin
    @(negedge ps2_clk or negedge rst_n);
    if (!rst_n) begin
      cap_n = 0;
    end else begin
      cap_bits[cap_n] = ps2_data;
      cap_n++;
      if (cap_n == 11) begin
        cap_q.push_back(cap_bits);
        cap_n = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse(input logic e, input logic s);
    @(posedge clk); #1;
    enter = e; space = s;
    @(posedge clk); #1;
    enter = 0; space = 0;
  endtask

  task automatic clear_logs();
    cap_q.delete();
    dur_q.delete();
    gap_q.delete();
    have_done = 0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_busy(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      k++;
      if (busy === 1'b1) break;
    end
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic expect_frame(input string name, input logic [10:0] exp);
    if (cap_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no frame expected %0h", name, exp);
    end else begin
      check(name, 32'(cap_q.pop_front()), 32'(exp));
    end
  endtask

  task automatic expect_key(input string name, input logic [10:0] make);
    expect_frame(name, make);
`ifdef KEY_BREAK_EN
    expect_frame({name, "_break"}, BREAK_FRAME);
    expect_frame({name, "_make2"}, make);
`endif
  endtask

  task automatic expect_dur(input string name);
    if (dur_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no duration expected %0d", name, SEQ_CYC);
    end else begin
      check(name, 32'(dur_q.pop_front()), 32'(SEQ_CYC));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    enter = 0; space = 0; rst_n = 0;
    repeat (3) @(posedge clk);
    chk_on = 1;
    @(negedge clk);
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_data", 32'(ps2_data), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("model_enter_frame", 32'(frame_of(8'h5A)), 32'(ENTER_FRAME));
    check("model_space_frame", 32'(frame_of(8'h29)), 32'(SPACE_FRAME));
    check("model_break_frame", 32'(frame_of(8'hF0)), 32'(BREAK_FRAME));
    @(posedge clk); #1;
    rst_n = 1;
    repeat (5) @(posedge clk);

    // Enter alone
    clear_logs();
    base = done_cnt;
    pulse(1, 0);
    wait_done(base + 1, 4 * SEQ_CYC);
    repeat (10) @(negedge clk);
    expect_key("enter_frame", ENTER_FRAME);
    expect_dur("enter_duration");
    check("enter_no_extra", 32'(cap_q.size()), 32'd0);
    check("enter_idle_busy", 32'(busy), 32'd0);

    // Space alone
    clear_logs();
    base = done_cnt;
    pulse(0, 1);
    wait_done(base + 1, 4 * SEQ_CYC);
    repeat (10) @(negedge clk);
    expect_key("space_frame", SPACE_FRAME);
    expect_dur("space_duration");
    check("space_no_extra", 32'(cap_q.size()), 32'd0);

    // Both at once: Enter then Space back to back
    clear_logs();
    base = done_cnt;
    pulse(1, 1);
    wait_done(base + 2, 8 * SEQ_CYC);
    repeat (10) @(negedge clk);
    expect_key("both_first", ENTER_FRAME);
    expect_key("both_second", SPACE_FRAME);
    expect_dur("both_dur1");
    expect_dur("both_dur2");
    check("both_restart_gap", 32'(gap_q.size() > 0 ? gap_q.pop_front() : -1), 32'd1);
    check("both_done_count", 32'(done_cnt - base), 32'd2);

    // Re-request during a sequence, third request while pending is dropped
    clear_logs();
    base = done_cnt;
    pulse(1, 0);
    wait_busy(20);
    repeat (20) @(posedge clk);
    pulse(1, 0);
    repeat (10) @(posedge clk);
    pulse(1, 0);
    wait_done(base + 2, 8 * SEQ_CYC);
    repeat (3 * SEQ_CYC) @(negedge clk);
    check("rereq_done_count", 32'(done_cnt - base), 32'd2);
    check("rereq_frames", 32'(cap_q.size()), 32'(2 * SEQ_FRAMES));
    expect_key("rereq_first", ENTER_FRAME);
    expect_key("rereq_second", ENTER_FRAME);

    // Reset during the low phase of bit 5
    clear_logs();
    base = done_cnt;
    pulse(1, 0);
    wait_busy(20);
    repeat (45) @(posedge clk);
    #3;
    check("bit5_clk_low", 32'(ps2_clk), 32'd0);
    rst_n = 0;
    #1;
    check("abort_ps2_clk", 32'(ps2_clk), 32'd1);
    check("abort_ps2_data", 32'(ps2_data), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (300) @(negedge clk);
    check("abort_no_frames", 32'(cap_q.size()), 32'd0);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
